// File: rtl/order_book_pkg.sv
// Shared types and helpers for the order message decoder: message type codes,
// ASCII type bytes and the raw type byte decoder.
package order_book_pkg;

  typedef enum logic [1:0] {
    MT_ADD = 2'b00,
    MT_DEL = 2'b01,
    MT_EXE = 2'b10,
    MT_UNK = 2'b11
  } msg_type_t;

  localparam logic [7:0] ASC_ADD = 8'h53;
  localparam logic [7:0] ASC_DEL = 8'h44;
  localparam logic [7:0] ASC_EXE = 8'h45;

  // MT_UNK never reaches the FIFO; it only marks messages to be dropped.
  function automatic msg_type_t decode_type(input logic [7:0] type_byte);
    case (type_byte)
      ASC_ADD: decode_type = MT_ADD;
      ASC_DEL: decode_type = MT_DEL;
      ASC_EXE: decode_type = MT_EXE;
      default: decode_type = MT_UNK;
    endcase
  endfunction

endpackage

// File: rtl/order_obj_fifo.sv
// Synchronous FIFO holding decoded order objects; DEPTH must be a power of two
// so the pointers wrap naturally.
module order_obj_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Head reads as zero when empty so nothing stale is ever presented.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/order_msg_decoder.sv
// Decodes raw ITCH-style messages into order objects queued for the book engine.
// Optional saturating per-type statistics counters: define ORDER_PARSER_STATS_EN.
module order_msg_decoder
  import order_book_pkg::*;
#(
  parameter int MSG_W     = 320,
  parameter int STOCK_W   = 32,
  parameter int STOCK_LSB = 153,
  parameter int ORDER_W   = 32,
  parameter int ORDER_LSB = 218,
  parameter int QTY_W     = 32,
  parameter int QTY_LSB   = 112,
  parameter int PRICE_W   = 64,
  parameter int PRICE_LSB = 48,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = 32,
  localparam int OBJ_W    = 2 + STOCK_W + ORDER_W + QTY_W + PRICE_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MSG_W-1:0] in_msg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OBJ_W-1:0] out_obj,
  output logic             drop_pulse
`ifdef ORDER_PARSER_STATS_EN
  ,
  output logic [CNT_W-1:0] cnt_add,
  output logic [CNT_W-1:0] cnt_del,
  output logic [CNT_W-1:0] cnt_exe,
  output logic [CNT_W-1:0] cnt_drop
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  msg_type_t        in_type;
  logic             accept;
  logic             push;
  logic             full;
  logic             empty;
  logic [OBJ_W-1:0] push_obj;
  logic [CW-1:0]    unused_count;
  logic             unused_msg_bits;

  // Decode straight from the live input so an accepted message is never stale.
  assign in_type  = decode_type(in_msg[MSG_W-1 -: 8]);
  assign accept   = in_valid && in_ready;
  assign push     = accept && (in_type != MT_UNK);
  assign push_obj = {in_type,
                     in_msg[STOCK_LSB +: STOCK_W],
                     in_msg[ORDER_LSB +: ORDER_W],
                     in_msg[QTY_LSB   +: QTY_W],
                     in_msg[PRICE_LSB +: PRICE_W]};

  assign in_ready        = !full;
  assign out_valid       = !empty;
  assign unused_msg_bits = ^in_msg;

  order_obj_fifo #(
    .WIDTH (OBJ_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (push_obj),
    .pop       (out_ready),
    .pop_data  (out_obj),
    .full      (full),
    .empty     (empty),
    .count     (unused_count)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) drop_pulse <= 1'b0;
    else         drop_pulse <= accept && (in_type == MT_UNK);
  end

`ifdef ORDER_PARSER_STATS_EN
  // Each counter sticks at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_add  <= '0;
      cnt_del  <= '0;
      cnt_exe  <= '0;
      cnt_drop <= '0;
    end else if (accept) begin
      case (in_type)
        MT_ADD:  if (cnt_add  != '1) cnt_add  <= cnt_add  + CNT_W'(1);
        MT_DEL:  if (cnt_del  != '1) cnt_del  <= cnt_del  + CNT_W'(1);
        MT_EXE:  if (cnt_exe  != '1) cnt_exe  <= cnt_exe  + CNT_W'(1);
        default: if (cnt_drop != '1) cnt_drop <= cnt_drop + CNT_W'(1);
      endcase
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_order_msg_decoder.sv
// Scoreboard bench for order_msg_decoder: directed scenarios plus randomized
// traffic with random backpressure, checked against a field-level reference model.
module tb_order_msg_decoder;

  localparam int MSG_W = 320;
  localparam int OBJ_W = 162;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [MSG_W-1:0] in_msg = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [OBJ_W-1:0] out_obj;
  logic             drop_pulse;
`ifdef ORDER_PARSER_STATS_EN
  logic [31:0] cnt_add, cnt_del, cnt_exe, cnt_drop;
`endif

  int checks = 0;
  int errors = 0;

  // What the driver is currently presenting, as the model understands it.
  logic             cur_known = 1'b0;
  logic [1:0]       cur_code = 2'b00;
  logic [OBJ_W-1:0] cur_obj = '0;

  logic [OBJ_W-1:0] sb[$];
  logic             drop_exp = 1'b0;
  int               n_add = 0, n_del = 0, n_exe = 0, n_drop = 0;
  logic             rand_ready_en = 1'b0;

  order_msg_decoder dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_msg     (in_msg),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_obj    (out_obj),
    .drop_pulse (drop_pulse)
`ifdef ORDER_PARSER_STATS_EN
    ,
    .cnt_add    (cnt_add),
    .cnt_del    (cnt_del),
    .cnt_exe    (cnt_exe),
    .cnt_drop   (cnt_drop)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [OBJ_W-1:0] act,
                              input logic [OBJ_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Place each field at its documented byte position inside random filler.
  function automatic logic [MSG_W-1:0] build_msg(input logic [7:0] t, input logic [31:0] stock,
                                                 input logic [31:0] order, input logic [31:0] qty,
                                                 input logic [63:0] price);
    logic [MSG_W-1:0] m;
    for (int i = 0; i < MSG_W / 32; i++) m[i*32 +: 32] = $urandom();
    m[319:312] = t;
    m[153 +: 32] = stock;
    m[218 +: 32] = order;
    m[112 +: 32] = qty;
    m[48 +: 64]  = price;
    return m;
  endfunction

  // Drive one message from posedge+1 until accepted; returns at posedge+1.
  task automatic apply_stimulus(input logic [7:0] t, input logic [31:0] stock,
                                input logic [31:0] order, input logic [31:0] qty,
                                input logic [63:0] price);
    int waited = 0;
    in_msg    = build_msg(t, stock, order, qty, price);
    cur_known = 1'b1;
    case (t)
      8'h53:   cur_code = 2'b00;
      8'h44:   cur_code = 2'b01;
      8'h45:   cur_code = 2'b10;
      default: begin cur_code = 2'b11; cur_known = 1'b0; end
    endcase
    cur_obj  = {cur_code, stock, order, qty, price};
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 200) begin
        checks++;
        errors++;
        $display("[TB] FAIL accept_timeout: got in_ready=0 required 1 within 200 cycles");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_random(input logic [7:0] t);
    apply_stimulus(t, $urandom(), $urandom(), $urandom(), {$urandom(), $urandom()});
  endtask

  function automatic logic [7:0] rand_type();
    int r = $urandom_range(0, 9);
    logic [7:0] b;
    if (r < 3) return 8'h53;
    if (r < 6) return 8'h44;
    if (r < 9) return 8'h45;
    do b = 8'($urandom()); while (b == 8'h53 || b == 8'h44 || b == 8'h45);
    return b;
  endfunction

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d pending required 0", sb.size());
    end
  endtask

  // Monitor: compare DUT state to the model, then advance the model on handshakes.
  always @(negedge clk) begin
    if (!resetn) begin
      sb.delete();
      drop_exp = 1'b0;
      n_add = 0; n_del = 0; n_exe = 0; n_drop = 0;
    end else begin
      check_output("out_valid", OBJ_W'(out_valid), OBJ_W'(sb.size() != 0));
      check_output("in_ready", OBJ_W'(in_ready), OBJ_W'(sb.size() != DEPTH));
      check_output("drop_pulse", OBJ_W'(drop_pulse), OBJ_W'(drop_exp));
`ifdef ORDER_PARSER_STATS_EN
      check_output("cnt_add", OBJ_W'(cnt_add), OBJ_W'(n_add));
      check_output("cnt_del", OBJ_W'(cnt_del), OBJ_W'(n_del));
      check_output("cnt_exe", OBJ_W'(cnt_exe), OBJ_W'(n_exe));
      check_output("cnt_drop", OBJ_W'(cnt_drop), OBJ_W'(n_drop));
`endif
      if (out_valid && sb.size() != 0) begin
        check_output("out_obj", out_obj, sb[0]);
        if (out_ready) void'(sb.pop_front());
      end
      drop_exp = 1'b0;
      if (in_valid && in_ready) begin
        case (cur_code)
          2'b00:   n_add++;
          2'b01:   n_del++;
          2'b10:   n_exe++;
          default: n_drop++;
        endcase
        if (cur_known) sb.push_back(cur_obj);
        else drop_exp = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready_en) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset held with a valid message pending
    in_valid = 1'b1;
    in_msg   = build_msg(8'h53, 1, 2, 3, 4);
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_out_valid", OBJ_W'(out_valid), '0);
    check_output("reset_out_obj", out_obj, '0);
    in_valid = 1'b0;
    resetn   = 1'b1;
    #1;
    check_output("reset_in_ready", OBJ_W'(in_ready), OBJ_W'(1));
    check_output("reset_obj_after", out_obj, '0);
    @(posedge clk);
    #1;

    // Single add, visible the cycle after acceptance
    apply_stimulus(8'h53, 32'hAABBCCDD, 32'h11223344, 32'd100, 64'h1234);
    check_output("add_valid", OBJ_W'(out_valid), OBJ_W'(1));
    check_output("add_obj", out_obj,
                 {2'b00, 32'hAABBCCDD, 32'h11223344, 32'h00000064, 64'h1234});
    drain();

    // Delete then execute back to back with the sink always ready
    apply_stimulus(8'h44, 32'h1, 32'h2, 32'h3, 64'h4);
    check_output("del_type", OBJ_W'(out_obj[161:160]), OBJ_W'(2'b01));
    apply_stimulus(8'h45, 32'h5, 32'h6, 32'h7, 64'h8);
    check_output("exe_type", OBJ_W'(out_obj[161:160]), OBJ_W'(2'b10));
    drain();

    // Unknown type is consumed and only pulses drop_pulse
    send_random(8'h41);
    check_output("unk_no_valid", OBJ_W'(out_valid), '0);
    check_output("unk_drop", OBJ_W'(drop_pulse), OBJ_W'(1));
    @(posedge clk);
    #1;
    check_output("unk_drop_once", OBJ_W'(drop_pulse), '0);

    // Backpressure: five messages into a four-deep queue
    out_ready = 1'b0;
    fork
      for (int i = 0; i < 5; i++) send_random(8'h53 - 8'(i % 2) * 8'h0F);
      begin
        repeat (10) @(posedge clk);
        #1;
        check_output("bp_full", OBJ_W'(in_ready), '0);
        out_ready = 1'b1;
      end
    join
    drain();

    // Simultaneous push and pop with two entries queued
    out_ready = 1'b0;
    send_random(8'h53);
    send_random(8'h45);
    out_ready = 1'b1;
    send_random(8'h44);
    check_output("concurrent_valid", OBJ_W'(out_valid), OBJ_W'(1));
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    drain();

    // Randomized traffic with random sink readiness
    rand_ready_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      send_random(rand_type());
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rand_ready_en = 1'b0;
    @(posedge clk);
    #1;
    drain();

    // Asynchronous reset with objects queued
    out_ready = 1'b0;
    send_random(8'h53);
    send_random(8'h44);
    send_random(8'h45);
    #3;
    resetn = 1'b0;
    #1;
    check_output("async_out_valid", OBJ_W'(out_valid), '0);
    check_output("async_in_ready", OBJ_W'(in_ready), OBJ_W'(1));
    check_output("async_out_obj", out_obj, '0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send_random(8'h45);
    drain();
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
